// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and frame constants.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // States in which a frame is open and the inter-byte timeout is armed.
  function automatic logic in_frame(state_e s);
    return (s == ST_ADDR) || (s == ST_COUNT) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Clearable down-counter: o_expired rises after TIMEOUT_CYC consecutive uncleared cycles.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Loading TIMEOUT_CYC-1 on clear makes the count hit zero during the
  // TIMEOUT_CYC-th idle cycle, so the FSM leaves on that cycle's edge.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: writes payload into program RAM with the CPU
// halted, verifies an additive checksum, then pulses CPU reset to start from address 0.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(SYNC_DEFAULT),
  parameter int                TIMEOUT_CYC = 1024,
  parameter bit                HALT_AT_RST = 1'b1
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_cpu_halt,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic xfer;
  logic is_sync;
  logic expired;

  assign o_ready = (state_q != ST_DONE);
  assign xfer    = i_valid & o_ready;
  assign is_sync = (i_data == SYNC_BYTE);

  // Timer runs only while a frame is open; any accepted byte restarts it.
  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (i_clk),
    .reset    (reset),
    .i_clear  (xfer | ~in_frame(state_q)),
    .o_expired(expired)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    halt_d  = halt_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (xfer && is_sync) begin
          state_d = ST_ADDR;
          halt_d  = 1'b1;
          err_d   = 1'b0;
          sum_d   = '0;
        end
      end
      ST_ADDR: begin
        if (xfer) begin
          ptr_d   = i_data[ADDR_W-1:0];
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          left_d  = i_data;
          state_d = (i_data == '0) ? ST_CSUM : ST_DATA;
        end
      end
      ST_DATA: begin
        // Write is registered: o_we appears the cycle after the word is accepted.
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = i_data;
          ptr_d   = ptr_q + ADDR_W'(1);
          sum_d   = sum_q + i_data;
          left_d  = left_q - DATA_W'(1);
          if (left_q == DATA_W'(1)) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          if (i_data == sum_q) begin
            state_d = ST_DONE;
            err_d   = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        halt_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (in_frame(state_q) && !xfer && expired) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      left_q  <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      halt_q  <= HALT_AT_RST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_cpu_halt  = halt_q;
  assign o_cpu_reset = (state_q == ST_DONE);
  assign o_busy      = in_frame(state_q);
  assign o_err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte-level frame model checked every cycle plus literal expectations.
module tb_prog_loader;

  localparam int T    = 1024;
  localparam int SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_we, o_cpu_halt, o_cpu_reset, o_busy, o_err;
  logic [3:0] o_addr;
  logic [7:0] o_wdata;

  prog_loader #(
    .DATA_W(8), .ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T), .HALT_AT_RST(1'b1)
  ) dut (
    .i_clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_cpu_halt(o_cpu_halt), .o_cpu_reset(o_cpu_reset), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: hunt for SYNC, then count fields by position.
  bit m_hunt = 1, m_done = 0, m_err = 0, m_halt = 1, m_we = 0;
  int m_pos = 0, m_left = 0, m_sum = 0, m_ptr = 0, m_idle = 0, m_addr = 0, m_wdata = 0;

  task automatic model_step();
    bit acc;
    int d;
    d = int'(i_data);
    if (reset) begin
      m_hunt = 1; m_done = 0; m_err = 0; m_halt = 1; m_we = 0;
      m_pos = 0; m_left = 0; m_sum = 0; m_ptr = 0; m_idle = 0; m_addr = 0; m_wdata = 0;
      return;
    end
    m_we = 0;
    acc  = i_valid && !m_done;
    if (m_done) begin
      m_done = 0;
      m_halt = 0;
    end else if (m_hunt) begin
      if (acc && d == SYNC) begin
        m_hunt = 0; m_halt = 1; m_err = 0; m_pos = 0; m_sum = 0; m_idle = 0;
      end
    end else if (acc) begin
      m_idle = 0;
      case (m_pos)
        0: begin m_ptr = d % 16; m_pos = 1; end
        1: begin m_left = d; m_pos = (d == 0) ? 3 : 2; end
        2: begin
          m_we = 1; m_addr = m_ptr; m_wdata = d;
          m_ptr = (m_ptr + 1) % 16;
          m_sum = (m_sum + d) % 256;
          m_left--;
          if (m_left == 0) m_pos = 3;
        end
        default: begin
          m_hunt = 1;
          if (d == m_sum) begin m_done = 1; m_err = 0; end
          else m_err = 1;
        end
      endcase
    end else begin
      m_idle++;
      if (m_idle >= T) begin m_err = 1; m_hunt = 1; end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int         rst_pulses = 0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("ready", o_ready, !m_done);
      check("we", o_we, m_we);
      check("addr", o_addr, m_addr);
      check("wdata", o_wdata, m_wdata);
      check("halt", o_cpu_halt, m_halt);
      check("cpu_reset", o_cpu_reset, m_done);
      check("busy", o_busy, !m_hunt && !m_done);
      check("err", o_err, m_err);
      if (o_we === 1'b1) begin wa.push_back(o_addr); wd.push_back(o_wdata); end
      if (o_cpu_reset === 1'b1) rst_pulses++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   guard;
    i_valid = 1'b1;
    i_data  = b;
    guard   = 0;
    do begin
      @(posedge clk);
      acc = o_ready;
      #1;
      guard++;
    end while (!acc && guard < 20);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    rst_pulses = 0;
  endtask

  task automatic expect_wr(string nm, int idx, int a, int d);
    if (idx < wa.size()) begin
      check({nm, "_addr"}, wa[idx], a);
      check({nm, "_data"}, wd[idx], d);
    end else begin
      check({nm, "_missing"}, idx, wa.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_halt", o_cpu_halt, 1);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_we", o_we, 0);
    check("rst_addr", o_addr, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_cpu_reset", o_cpu_reset, 0);
    reset = 1'b0;
    idle(2);

    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    idle(3);
    $display("good frame: writes=%0d pulses=%0d halt=%0b err=%0b", wa.size(), rst_pulses, o_cpu_halt, o_err);
    check("good_nwr", wa.size(), 3);
    expect_wr("good0", 0, 4'h0, 8'h11);
    expect_wr("good1", 1, 4'h1, 8'h22);
    expect_wr("good2", 2, 4'h2, 8'h33);
    check("good_pulses", rst_pulses, 1);
    check("good_halt", o_cpu_halt, 0);
    check("good_err", o_err, 0);

    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04});
    idle(3);
    $display("bad csum: writes=%0d pulses=%0d halt=%0b err=%0b", wa.size(), rst_pulses, o_cpu_halt, o_err);
    check("bad_nwr", wa.size(), 2);
    expect_wr("bad0", 0, 4'h0, 8'h01);
    expect_wr("bad1", 1, 4'h1, 8'h02);
    check("bad_err", o_err, 1);
    check("bad_model_err", m_err, 1);
    check("bad_halt", o_cpu_halt, 1);
    check("bad_pulses", rst_pulses, 0);

    clear_log();
    send_frame('{8'hA5, 8'h0E, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31});
    idle(3);
    $display("wrap frame: writes=%0d pulses=%0d halt=%0b err=%0b", wa.size(), rst_pulses, o_cpu_halt, o_err);
    check("wrap_nwr", wa.size(), 3);
    expect_wr("wrap0", 0, 4'hE, 8'hAA);
    expect_wr("wrap1", 1, 4'hF, 8'hBB);
    expect_wr("wrap2", 2, 4'h0, 8'hCC);
    check("wrap_err", o_err, 0);
    check("wrap_pulses", rst_pulses, 1);

    clear_log();
    send_frame('{8'hA5, 8'h00});
    idle(T - 1);
    check("gap_short_err", o_err, 0);
    check("gap_short_busy", o_busy, 1);
    send_frame('{8'h01, 8'h5A, 8'h5A});
    idle(3);
    $display("gap T-1: writes=%0d pulses=%0d err=%0b", wa.size(), rst_pulses, o_err);
    check("gap_short_nwr", wa.size(), 1);
    expect_wr("gap_short0", 0, 4'h0, 8'h5A);
    check("gap_short_pulses", rst_pulses, 1);

    clear_log();
    send_frame('{8'hA5, 8'h00});
    idle(T);
    $display("gap T: busy=%0b err=%0b halt=%0b", o_busy, o_err, o_cpu_halt);
    check("timeout_err", o_err, 1);
    check("timeout_busy", o_busy, 0);
    check("timeout_halt", o_cpu_halt, 1);
    send_frame('{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    idle(3);
    $display("reload after timeout: writes=%0d pulses=%0d err=%0b", wa.size(), rst_pulses, o_err);
    check("reload_err", o_err, 0);
    check("reload_nwr", wa.size(), 3);
    check("reload_pulses", rst_pulses, 1);

    clear_log();
    send_frame('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00});
    idle(3);
    $display("garbage + count0: writes=%0d pulses=%0d err=%0b", wa.size(), rst_pulses, o_err);
    check("cnt0_nwr", wa.size(), 0);
    check("cnt0_pulses", rst_pulses, 1);
    check("cnt0_halt", o_cpu_halt, 0);

    clear_log();
    send_frame('{8'hA5, 8'h03, 8'h01, 8'hA5, 8'hA5});
    idle(3);
    $display("sync as payload: writes=%0d pulses=%0d", wa.size(), rst_pulses);
    expect_wr("syncpay", 0, 4'h3, 8'hA5);
    check("syncpay_pulses", rst_pulses, 1);

    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h05, 8'h01, 8'h02});
    reset   = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h03;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    i_valid = 1'b0;
    check("midrst_busy", o_busy, 0);
    check("midrst_we", o_we, 0);
    idle(5);
    $display("reset in DATA: writes=%0d busy=%0b halt=%0b", wa.size(), o_busy, o_cpu_halt);
    check("midrst_nwr", wa.size(), 2);
    check("midrst_halt", o_cpu_halt, 1);
    check("midrst_pulses", rst_pulses, 0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
